// File: rtl/coin_pkg.sv
// Shared coin codes, paise values and controller state encoding for the
// coin-collecting datapath.
package coin_pkg;

  localparam logic [1:0] COIN_25   = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_NONE = 2'b11;

  localparam logic [7:0] VAL_25  = 8'd25;
  localparam logic [7:0] VAL_50  = 8'd50;
  localparam logic [7:0] VAL_100 = 8'd100;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } vend_state_e;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      COIN_25:  v = VAL_25;
      COIN_50:  v = VAL_50;
      COIN_100: v = VAL_100;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_slot_buf.sv
// One-entry holding register for a coin inlet; drops and flags a coin that
// arrives while the entry is occupied and not being drained.
module coin_slot_buf
  import coin_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  input  logic       pop,
  output logic       full,
  output logic [7:0] value,
  output logic       reject
);

  logic       full_q, full_d;
  logic [7:0] value_q, value_d;
  logic       reject_q, reject_d;
  logic       arrive;

  // A pop at the same edge frees the entry, so back-to-back coins stream
  // through at one per cycle.
  always_comb begin
    arrive   = (coin != COIN_NONE);
    full_d   = full_q;
    value_d  = value_q;
    reject_d = 1'b0;
    if (pop) begin
      full_d = 1'b0;
    end
    if (arrive) begin
      if (!full_q || pop) begin
        full_d  = 1'b1;
        value_d = coin_value(coin);
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q   <= 1'b0;
      value_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      value_q  <= value_d;
      reject_q <= reject_d;
    end
  end

  assign full   = full_q;
  assign value  = value_q;
  assign reject = reject_q;

endmodule

// File: rtl/coin_vend_ctrl.sv
// Vending transaction controller: two buffered coin slots, round-robin
// arbitration into one credit accumulator, vend and 25p change payout.
module coin_vend_ctrl
  import coin_pkg::*;
#(
  parameter int unsigned PRICE   = 100,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       vend,
  output logic       change_pulse,
  output logic       busy,
  output logic       grant_a,
  output logic       grant_b,
  output logic       reject_a,
  output logic       reject_b
);

  localparam logic [7:0] PRICE_L   = PRICE[7:0];
  localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

  logic        full_a, full_b;
  logic [7:0]  val_a, val_b;

  vend_state_e state_q, state_d;
  logic [7:0]  credit_q, credit_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        rr_b_q, rr_b_d;
  logic        vend_q, vend_d;
  logic        change_q, change_d;
  logic        busy_q, busy_d;

  logic        grant_en, grant_any;
  logic [7:0]  add_val, sum;

  coin_slot_buf u_slot_a (
    .clock  (clock),
    .reset  (reset),
    .coin   (coin_a),
    .pop    (grant_a),
    .full   (full_a),
    .value  (val_a),
    .reject (reject_a)
  );

  coin_slot_buf u_slot_b (
    .clock  (clock),
    .reset  (reset),
    .coin   (coin_b),
    .pop    (grant_b),
    .full   (full_b),
    .value  (val_b),
    .reject (reject_b)
  );

  // Cancel in COLLECT blocks the grant so the pending coin stays buffered.
  always_comb begin
    grant_en  = (state_q == IDLE) || ((state_q == COLLECT) && !cancel);
    grant_a   = grant_en && full_a && (!full_b || !rr_b_q);
    grant_b   = grant_en && full_b && (!full_a || rr_b_q);
    grant_any = grant_a || grant_b;
    add_val   = grant_a ? val_a : (grant_b ? val_b : '0);
    sum       = credit_q + add_val;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = '0;
    rr_b_d   = rr_b_q;
    if (full_a && full_b && grant_any) begin
      rr_b_d = grant_a;
    end
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          credit_d = sum;
          state_d  = (sum >= PRICE_L) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d = CHANGE;
        end else if (grant_any) begin
          credit_d = sum;
          if (sum >= PRICE_L) begin
            state_d = VEND;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TIMEOUT_L) begin
            state_d = CHANGE;
          end
        end
      end
      VEND: begin
        credit_d = credit_q - PRICE_L;
        state_d  = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        credit_d = credit_q - VAL_25;
        if (credit_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    vend_d   = (state_d == VEND);
    change_d = (state_d == CHANGE);
    busy_d   = vend_d || change_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      rr_b_q   <= 1'b0;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      rr_b_q   <= rr_b_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      busy_q   <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign vend         = vend_q;
  assign change_pulse = change_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Bench for coin_vend_ctrl: directed scenarios plus random coin traffic, all
// checked cycle by cycle against a transaction-level credit model.
module tb_coin_vend_ctrl;

  localparam int PRICE   = 100;
  localparam int TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] coin_a, coin_b;
  logic       cancel;
  logic [7:0] credit;
  logic       vend, change_pulse, busy;
  logic       grant_a, grant_b, reject_a, reject_b;

  int checks = 0;
  int errors = 0;

  coin_vend_ctrl #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .coin_a       (coin_a),
    .coin_b       (coin_b),
    .cancel       (cancel),
    .credit       (credit),
    .vend         (vend),
    .change_pulse (change_pulse),
    .busy         (busy),
    .grant_a      (grant_a),
    .grant_b      (grant_b),
    .reject_a     (reject_a),
    .reject_b     (reject_b)
  );

  always #5 clock = ~clock;

  // Model: a payout phase is "vend this cycle" or "paying change"; otherwise
  // the machine is idle when credit is zero and collecting when it is not.
  bit m_fa, m_fb, m_ptr_b, m_vend, m_change, m_rej_a, m_rej_b;
  int m_va, m_vb, m_credit, m_idle;
  bit e_ga, e_gb;

  function automatic int paise(input logic [1:0] c);
    case (c)
      2'd0:    return 25;
      2'd1:    return 50;
      2'd2:    return 100;
      default: return 0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fa = 0; m_fb = 0; m_ptr_b = 0; m_vend = 0; m_change = 0;
    m_rej_a = 0; m_rej_b = 0; m_va = 0; m_vb = 0; m_credit = 0; m_idle = 0;
  endtask

  task automatic model_edge(input logic [1:0] a, input logic [1:0] b, input bit c, input bit r);
    bit arr_a, arr_b;
    int gv, nidle;
    if (r) begin
      model_reset();
      return;
    end
    arr_a = (a != 2'b11);
    arr_b = (b != 2'b11);
    m_rej_a = arr_a && m_fa && !e_ga;
    m_rej_b = arr_b && m_fb && !e_gb;
    if (m_fa && m_fb && (e_ga || e_gb)) m_ptr_b = e_ga;
    gv = e_ga ? m_va : (e_gb ? m_vb : 0);
    if (e_ga) m_fa = 0;
    if (e_gb) m_fb = 0;
    if (arr_a && !m_fa) begin m_fa = 1; m_va = paise(a); end
    if (arr_b && !m_fb) begin m_fb = 1; m_vb = paise(b); end
    nidle = 0;
    if (m_vend) begin
      m_credit -= PRICE;
      m_vend = 0;
      m_change = (m_credit > 0);
    end else if (m_change) begin
      m_credit -= 25;
      m_change = (m_credit > 0);
    end else if (m_credit > 0 && c) begin
      m_change = 1;
    end else if (gv > 0) begin
      m_credit += gv;
      if (m_credit >= PRICE) m_vend = 1;
    end else if (m_credit > 0) begin
      nidle = m_idle + 1;
      if (nidle == TIMEOUT) m_change = 1;
    end
    m_idle = nidle;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic [1:0] a, input logic [1:0] b, input bit c, input bit r);
    bit free;
    coin_a = a; coin_b = b; cancel = c; reset = r;
    free = !m_vend && !m_change && !(m_credit > 0 && c);
    e_ga = free && m_fa && (!m_fb || !m_ptr_b);
    e_gb = free && m_fb && (!m_fa || m_ptr_b);
    @(negedge clock);
    check_eq("credit",       32'(credit),       32'(m_credit));
    check_eq("vend",         32'(vend),         32'(m_vend));
    check_eq("change_pulse", 32'(change_pulse), 32'(m_change));
    check_eq("busy",         32'(busy),         32'(m_vend || m_change));
    check_eq("grant_a",      32'(grant_a),      32'(e_ga));
    check_eq("grant_b",      32'(grant_b),      32'(e_gb));
    check_eq("reject_a",     32'(reject_a),     32'(m_rej_a));
    check_eq("reject_b",     32'(reject_b),     32'(m_rej_b));
    model_edge(a, b, c, r);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] rand_coin();
    int unsigned r;
    r = $urandom_range(0, 7);
    return (r < 4) ? 2'b11 : 2'(r - 4);
  endfunction

  initial begin
    coin_a = 2'b11; coin_b = 2'b11; cancel = 1'b1; reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0; cancel = 1'b0;

    // Reset state, then four 25p coins on slot A.
    step(2'b11, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 0, 0);

    // Simultaneous 50p/100p, vend with two change coins, then a B-first pair.
    step(2'b01, 2'b10, 0, 0);
    for (int i = 0; i < 7; i++) step(2'b11, 2'b11, 0, 0);
    step(2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 0, 0);
    step(2'b11, 2'b11, 1, 0);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 0, 0);

    // 75p then cancel; coins during CHANGE buffered then one rejected.
    step(2'b00, 2'b11, 0, 0);
    step(2'b01, 2'b11, 0, 0);
    step(2'b11, 2'b11, 0, 0);
    step(2'b11, 2'b11, 0, 0);
    step(2'b11, 2'b11, 1, 0);
    step(2'b00, 2'b11, 0, 0);
    step(2'b01, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) step(2'b11, 2'b11, 0, 0);

    // Timeout refund of a single 50p coin (slot A still holds 25p from above).
    step(2'b11, 2'b11, 1, 0);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, 0, 0);
    step(2'b01, 2'b11, 0, 0);
    for (int i = 0; i < 14; i++) step(2'b11, 2'b11, 0, 0);

    // Reset asserted mid-CHANGE.
    for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 0, 0);
    step(2'b11, 2'b11, 0, 0);
    step(2'b11, 2'b11, 1, 0);
    step(2'b11, 2'b11, 0, 1);
    step(2'b11, 2'b11, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      step(rand_coin(), rand_coin(), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
